vu_vxu_b8_vsdq: RTL and testbench

- Vector store-data queue directly downstream of the banked-8 lane's VSU read port.
- Captures every store element the lane emits on vsu_val/vsu_rdata; the lane port has no ready, so capture is unconditional.
- Presents the captured elements to the memory side as a decoupled val/rdy stream.
- Drives vsdq_qstall back to the sequencer so that a fired store can never overrun the queue; reservations are made at fire time.

---
 rtl/vu_vxu_b8_vsdq.sv | 106 ++++++++++
 tb/tb_vu_vxu_b8_vsdq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vu_vxu_b8_vsdq.sv
// Vector store-data queue behind the banked-8 lane VSU read port.
// Captures lane store elements unconditionally, drains them as a val/rdy stream, and stalls the sequencer on reservations.
module vu_vxu_b8_vsdq #(
    parameter int unsigned DATA_WIDTH   = 65,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned STALL_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_val,
    input  logic [DATA_WIDTH-1:0] enq_bits,
    input  logic                  resv_val,
    input  logic [ADDR_BITS:0]    resv_cnt,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [DATA_WIDTH-1:0] deq_bits,
    output logic                  qstall,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow
);

    localparam int unsigned CW = ADDR_BITS + 1;
    localparam int unsigned SW = ADDR_BITS + 2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);
    localparam logic [SW-1:0] THRESH_S = SW'(DEPTH - STALL_THRESH);

    logic [ADDR_BITS-1:0]  head_q, head_d;
    logic [ADDR_BITS-1:0]  tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         resv_q, resv_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] ram_q [DEPTH];

    logic          deq_fire;
    logic          full;
    logic          acc_enq;
    logic          drop;
    logic          resv_nz;
    logic [SW-1:0] resv_sum;
    logic [SW-1:0] occ_sum;

    assign deq_val  = (count_q != '0);
    assign deq_fire = deq_val & deq_rdy;
    assign full     = (count_q == DEPTH_C);
    assign acc_enq  = enq_val & (~full | deq_fire);
    assign drop     = enq_val & full & ~deq_fire;
    assign resv_nz  = (resv_q != '0);

    // resv_nz guards the decrement, so the sum can never underflow.
    assign resv_sum = SW'(resv_q) + (resv_val ? SW'(resv_cnt) : SW'(0))
                    - SW'(enq_val & resv_nz);

    assign occ_sum  = SW'(count_q) + SW'(resv_q);
    assign qstall   = (occ_sum > THRESH_S);
    assign count    = count_q;
    assign overflow = ovf_q;
    // Gated so no uninitialised RAM contents reach the memory side.
    assign deq_bits = deq_val ? ram_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(acc_enq) - CW'(deq_fire);
        resv_d  = resv_sum[CW-1:0];
        ovf_d   = ovf_q;
        if (acc_enq) begin
            tail_d = tail_q + ADDR_BITS'(1);
        end
        if (deq_fire) begin
            head_d = head_q + ADDR_BITS'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (resv_sum > DEPTH_S) begin
            resv_d = DEPTH_C;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            resv_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            resv_q  <= resv_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (acc_enq) begin
            ram_q[tail_q] <= enq_bits;
        end
    end

endmodule

// File: tb/tb_vu_vxu_b8_vsdq.sv
// Randomised scoreboard bench for vu_vxu_b8_vsdq: a queue-based model predicts occupancy,
// reservations, stall and overflow; a monitor checks head data in order.
module tb_vu_vxu_b8_vsdq;

    localparam int unsigned DW    = 65;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AB    = 4;
    localparam int unsigned THR   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enq_val;
    logic [DW-1:0] enq_bits;
    logic          resv_val;
    logic [AB:0]   resv_cnt;
    logic          deq_val;
    logic          deq_rdy;
    logic [DW-1:0] deq_bits;
    logic          qstall;
    logic [AB:0]   count;
    logic          overflow;

    vu_vxu_b8_vsdq #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB), .STALL_THRESH(THR)
    ) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_bits(enq_bits),
        .resv_val(resv_val), .resv_cnt(resv_cnt),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_bits(deq_bits),
        .qstall(qstall), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb[$];
    int m_cnt  = 0;
    int m_resv = 0;
    bit m_ovf  = 1'b0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy and reservations as plain integers, accepted data into the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            m_cnt  = 0;
            m_resv = 0;
            m_ovf  = 1'b0;
            sb.delete();
        end else begin
            bit fire, acc;
            int r;
            check("count", 96'(count), 96'(m_cnt));
            check("deq_val", 96'(deq_val), 96'(m_cnt != 0));
            check("qstall", 96'(qstall), 96'((m_cnt + m_resv) > int'(DEPTH - THR)));
            check("overflow", 96'(overflow), 96'(m_ovf));
            fire = (m_cnt != 0) && deq_rdy;
            acc  = enq_val && ((m_cnt < int'(DEPTH)) || fire);
            if (acc) sb.push_back(enq_bits);
            else if (enq_val) m_ovf = 1'b1;
            m_cnt = m_cnt + int'(acc) - int'(fire);
            r = m_resv + (resv_val ? int'(resv_cnt) : 0) - ((enq_val && m_resv != 0) ? 1 : 0);
            if (r > int'(DEPTH)) begin
                r = int'(DEPTH);
                m_ovf = 1'b1;
            end
            m_resv = r;
        end
    end

    // Monitor: head data must match the oldest expected element; pop on each dequeue.
    always @(negedge clk) begin
        if (!reset && deq_val) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 96'(0), 96'(1));
            end else begin
                check("deq_bits", 96'(deq_bits), 96'(sb[0]));
                if (deq_rdy) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input bit ev, input logic [DW-1:0] eb, input bit rv,
                       input int rc, input bit dr);
        @(posedge clk);
        #1;
        enq_val  = ev;
        enq_bits = eb;
        resv_val = rv;
        resv_cnt = (AB+1)'(rc);
        deq_rdy  = dr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        enq_val = 1'b0; resv_val = 1'b0; deq_rdy = 1'b0;
        #1;
        check("rst_count", 96'(count), 96'(0));
        check("rst_deq_val", 96'(deq_val), 96'(0));
        check("rst_qstall", 96'(qstall), 96'(0));
        check("rst_overflow", 96'(overflow), 96'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    initial begin
        reset = 1'b1;
        enq_val = 1'b0; enq_bits = '0; resv_val = 1'b0; resv_cnt = '0; deq_rdy = 1'b1;
        #23;
        reset = 1'b0;
        deq_rdy = 1'b1;
        repeat (3) cyc(0, '0, 0, 0, 1);

        // Reset mid-stream with five entries held.
        for (int i = 0; i < 5; i++) cyc(1, DW'(100 + i), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        do_reset();

        // Reserved burst of three, then drain in order.
        cyc(0, '0, 1, 3, 0);
        for (int i = 1; i <= 3; i++) cyc(1, DW'(i), 0, 0, 0);
        repeat (5) cyc(0, '0, 0, 0, 1);

        // Reservation of nine forces a stall until the elements flow.
        cyc(0, '0, 1, 9, 1);
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, DW'(200 + i), 0, 0, 1);
        repeat (3) cyc(0, '0, 0, 0, 1);

        // Reservation and unreserved element in the same cycle.
        cyc(1, DW'(77), 1, 4, 0);
        cyc(0, '0, 0, 0, 0);
        repeat (4) cyc(1, DW'(78), 0, 0, 1);
        repeat (3) cyc(0, '0, 0, 0, 1);
        do_reset();

        // Fill to full, overflow on a blocked enqueue, then full-plus-dequeue.
        for (int i = 1; i <= 16; i++) cyc(1, DW'(i), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(1, DW'(17), 0, 0, 0);
        cyc(0, '0, 0, 0, 0);
        cyc(1, DW'(18), 0, 0, 1);
        cyc(0, '0, 0, 0, 0);
        repeat (18) cyc(0, '0, 0, 0, 1);
        do_reset();

        // Wrap-around stream with toggling ready.
        for (int i = 1; i <= 40; i++) cyc(1, DW'(i), 0, 0, (i % 2) == 1);
        repeat (20) cyc(0, '0, 0, 0, 1);
        check("wrap_drained", 96'(sb.size()), 96'(0));
        do_reset();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 6, rnd_data(), $urandom_range(0, 19) == 0,
                $urandom_range(1, 16), $urandom_range(0, 1) == 1);
        end
        repeat (24) cyc(0, '0, 0, 0, 1);
        @(negedge clk);
        check("final_drained", 96'(sb.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
